// File: rtl/bit_destuff.sv
// CAN receive-path bit de-stuffer: drops the stuff bit after STUFF_LEN equal bits,
// forwards data bits with a valid strobe and flags stuff violations (sticky).
//
// state  | meaning
// IDLE   | no frame in progress; waiting for the first sample with enable high
// ACTIVE | forwarding data bits, tracking the current run of equal bits
// DROP   | a full run was seen; the next sampled bit must be the inverted stuff bit
// ERROR  | stuff violation seen; samples ignored until enable low or reset
module bit_destuff #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             sample,
  input  logic             rx_bit,
  output logic             dout,
  output logic             dvalid,
  output logic             stuff_drop,
  output logic             stuff_err,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {IDLE, ACTIVE, DROP, ERROR} state_t;

  localparam logic [3:0]       RUN_FULL = 4'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t           state, state_nxt;
  logic [3:0]       run_len, run_nxt;
  logic             prev, prev_nxt;
  logic             dout_nxt, dvalid_nxt, drop_nxt, err_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             emit;

  always_ff @(negedge clock) begin
    if (reset) begin
      state      <= IDLE;
      run_len    <= '0;
      prev       <= 1'b0;
      dout       <= 1'b0;
      dvalid     <= 1'b0;
      stuff_drop <= 1'b0;
      stuff_err  <= 1'b0;
      bit_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      run_len    <= run_nxt;
      prev       <= prev_nxt;
      dout       <= dout_nxt;
      dvalid     <= dvalid_nxt;
      stuff_drop <= drop_nxt;
      stuff_err  <= err_nxt;
      bit_cnt    <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    run_nxt    = run_len;
    prev_nxt   = prev;
    dout_nxt   = dout;
    dvalid_nxt = 1'b0;
    drop_nxt   = 1'b0;
    err_nxt    = stuff_err;
    cnt_nxt    = bit_cnt;
    emit       = 1'b0;

    if (!enable) begin
      // leaving the frame window wipes everything, including the sticky error
      state_nxt = IDLE;
      run_nxt   = '0;
      prev_nxt  = 1'b0;
      dout_nxt  = 1'b0;
      err_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else if (sample) begin
      case (state)
        IDLE: begin
          emit      = 1'b1;
          prev_nxt  = rx_bit;
          run_nxt   = 4'd1;
          state_nxt = ACTIVE;
        end
        ACTIVE: begin
          emit = 1'b1;
          if (rx_bit == prev) begin
            run_nxt = run_len + 4'd1;
          end else begin
            run_nxt  = 4'd1;
            prev_nxt = rx_bit;
          end
          if (run_nxt == RUN_FULL) state_nxt = DROP;
        end
        DROP: begin
          if (rx_bit != prev) begin
            drop_nxt  = 1'b1;
            prev_nxt  = rx_bit;
            run_nxt   = 4'd1;
            state_nxt = ACTIVE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ERROR;
          end
        end
        ERROR: begin
        end
        default: state_nxt = IDLE;
      endcase

      if (emit) begin
        dout_nxt   = rx_bit;
        dvalid_nxt = 1'b1;
        if (bit_cnt != CNT_SAT) cnt_nxt = bit_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_bit_destuff.sv
// Self-checking bench for bit_destuff: directed vector table, hand sequences,
// and biased random traffic against a stream-history reference model.
module tb_bit_destuff;

  logic clock;
  logic reset, enable, sample, rx_bit;

  logic       dout0, dvalid0, stuff_drop0, stuff_err0;
  logic [7:0] bit_cnt0;
  logic       dout1, dvalid1, stuff_drop1, stuff_err1;
  logic [2:0] bit_cnt1;

  int checks   = 0;
  int failures = 0;

  bit_destuff #(.STUFF_LEN(5), .CNT_W(8)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .sample(sample), .rx_bit(rx_bit),
    .dout(dout0), .dvalid(dvalid0), .stuff_drop(stuff_drop0), .stuff_err(stuff_err0),
    .bit_cnt(bit_cnt0)
  );

  bit_destuff #(.STUFF_LEN(3), .CNT_W(3)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .sample(sample), .rx_bit(rx_bit),
    .dout(dout1), .dvalid(dvalid1), .stuff_drop(stuff_drop1), .stuff_err(stuff_err1),
    .bit_cnt(bit_cnt1)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: keeps the recent on-wire stream (data plus stuff bits) of the
  // current frame; a stuff bit is due when the stream ends in STUFF_LEN equal bits.
  int          m_slen[2] = '{5, 3};
  int          m_cmax[2] = '{255, 7};
  logic [15:0] m_hist[2];
  int          m_hlen[2];
  bit          m_dout[2], m_dv[2], m_drop[2], m_err[2];
  int          m_cnt[2];

  task automatic model_step(int k, bit r, bit en, bit s, bit b);
    int run;
    if (r || !en) begin
      m_hist[k] = '0; m_hlen[k] = 0; m_dout[k] = 0; m_dv[k] = 0;
      m_drop[k] = 0;  m_err[k]  = 0; m_cnt[k]  = 0;
      return;
    end
    m_dv[k]   = 0;
    m_drop[k] = 0;
    if (!s || m_err[k]) return;
    run = 0;
    for (int i = 0; i < m_hlen[k]; i++) begin
      if (m_hist[k][i] != m_hist[k][0]) break;
      run++;
    end
    if (m_hlen[k] > 0 && run >= m_slen[k]) begin
      if (b != m_hist[k][0]) begin
        m_drop[k] = 1;
        m_hist[k] = {m_hist[k][14:0], b};
        if (m_hlen[k] < 16) m_hlen[k]++;
      end else begin
        m_err[k] = 1;
      end
    end else begin
      m_dout[k] = b;
      m_dv[k]   = 1;
      if (m_cnt[k] < m_cmax[k]) m_cnt[k]++;
      m_hist[k] = {m_hist[k][14:0], b};
      if (m_hlen[k] < 16) m_hlen[k]++;
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic step(bit r, bit en, bit s, bit b);
    @(posedge clock);
    #1;
    reset = r; enable = en; sample = s; rx_bit = b;
    model_step(0, r, en, s, b);
    model_step(1, r, en, s, b);
    @(negedge clock);
    #1;
  endtask

  typedef struct {
    bit r, en, s, b;
    bit dv, dout, drop, err;
    int cnt;
  } vec_t;

  vec_t vt[$];

  function automatic void add(bit r, bit en, bit s, bit b, bit dv, bit d, bit dr, bit er, int c);
    vec_t v;
    v.r = r; v.en = en; v.s = s; v.b = b;
    v.dv = dv; v.dout = d; v.drop = dr; v.err = er; v.cnt = c;
    vt.push_back(v);
  endfunction

  int  dv_cnt0, dv_cnt1, drop_cnt0;
  bit  lastb, r, en, s, b;

  initial begin
    reset = 1'b1; enable = 1'b0; sample = 1'b0; rx_bit = 1'b0;

    // reset, then 1,1,1,1,1,0(stuff),1
    add(1,0,0,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);
    for (int i = 1; i <= 5; i++) add(0,1,1,1, 1,1,0,0,i);
    add(0,1,1,0, 0,1,1,0,5);
    add(0,1,1,1, 1,1,0,0,6);
    add(0,1,0,0, 0,1,0,0,6);
    add(0,0,0,0, 0,0,0,0,0);
    // six zeros -> stuff error, sticky until enable low
    for (int i = 1; i <= 5; i++) add(0,1,1,0, 1,0,0,0,i);
    add(0,1,1,0, 0,0,0,1,5);
    add(0,1,1,0, 0,0,0,1,5);
    add(0,1,1,1, 0,0,0,1,5);
    add(0,1,0,0, 0,0,0,1,5);
    add(0,0,0,0, 0,0,0,0,0);
    // stuff bit starts a new run
    for (int i = 1; i <= 5; i++) add(0,1,1,0, 1,0,0,0,i);
    add(0,1,1,1, 0,0,1,0,5);
    for (int i = 6; i <= 9; i++) add(0,1,1,1, 1,1,0,0,i);
    add(0,1,1,0, 0,1,1,0,9);
    add(0,1,1,0, 1,0,0,0,10);
    // enable low beats a simultaneous sample
    add(0,0,1,1, 0,0,0,0,0);
    // reset while waiting for the stuff bit, then a fresh run of five
    for (int i = 1; i <= 5; i++) add(0,1,1,1, 1,1,0,0,i);
    add(1,1,1,1, 0,0,0,0,0);
    for (int i = 1; i <= 5; i++) add(0,1,1,1, 1,1,0,0,i);
    add(0,1,1,0, 0,1,1,0,5);
    add(0,0,0,0, 0,0,0,0,0);
    // reset out of the error state
    for (int i = 1; i <= 5; i++) add(0,1,1,1, 1,1,0,0,i);
    add(0,1,1,1, 0,1,0,1,5);
    add(1,1,1,0, 0,0,0,0,0);
    add(0,1,0,0, 0,0,0,0,0);

    foreach (vt[i]) begin
      step(vt[i].r, vt[i].en, vt[i].s, vt[i].b);
      chk($sformatf("vec%0d_flags", i), 32'({dvalid0, dout0, stuff_drop0, stuff_err0}),
          32'({vt[i].dv, vt[i].dout, vt[i].drop, vt[i].err}));
      chk($sformatf("vec%0d_cnt", i), 32'(bit_cnt0), vt[i].cnt);
    end

    // 20 alternating bits back to back; the 3-bit counter instance saturates at 7
    step(0, 0, 0, 0);
    dv_cnt0 = 0; dv_cnt1 = 0; drop_cnt0 = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 1'(i % 2));
      dv_cnt0   += 32'(dvalid0);
      dv_cnt1   += 32'(dvalid1);
      drop_cnt0 += 32'(stuff_drop0);
      if (i == 8) begin
        chk("sat9_cnt", 32'(bit_cnt1), 7);
        chk("sat9_dvalid", 32'(dvalid1), 1);
      end
    end
    chk("alt_dvalid_count", dv_cnt0, 20);
    chk("alt_drop_count", drop_cnt0, 0);
    chk("alt_cnt", 32'(bit_cnt0), 20);
    chk("alt_sat_dvalid_count", dv_cnt1, 20);
    chk("alt_sat_cnt", 32'(bit_cnt1), 7);

    // biased random traffic: long runs are likely, so drops and errors both occur
    step(1, 0, 0, 0);
    lastb = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      r  = ($urandom_range(0, 299) == 0);
      en = ($urandom_range(0, 79) != 0);
      s  = 1'($urandom_range(0, 1));
      b  = ($urandom_range(0, 3) == 0) ? ~lastb : lastb;
      lastb = b;
      step(r, en, s, b);
      chk("rand_inst0", 32'({dout0, dvalid0, stuff_drop0, stuff_err0, bit_cnt0}),
          32'({m_dout[0], m_dv[0], m_drop[0], m_err[0], 8'(m_cnt[0])}));
      chk("rand_inst1", 32'({dout1, dvalid1, stuff_drop1, stuff_err1, bit_cnt1}),
          32'({m_dout[1], m_dv[1], m_drop[1], m_err[1], 3'(m_cnt[1])}));
      chk("rand_excl", 32'((dvalid0 & stuff_drop0) | (dvalid1 & stuff_drop1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
